// File: rtl/parity_pkg.sv
// Shared definitions for both ends of the parity-protected serial link.
//
// Contents:
//   DEFAULT_DATA_BITS - default data width of one frame.
//   tx_state_t        - transmitter FSM encoding (IDLE, SHIFT, PARITY).
//   chk_state_t       - checker FSM encoding. It lives here so that the
//                       transmitter and the far-end checker decode state
//                       debug buses identically.
package parity_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    CHK_IDLE   = 2'd0,
    CHK_DATA   = 2'd1,
    CHK_PARITY = 2'd2
  } chk_state_t;

endpackage

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: parallel-in, serial-out transmitter with a trailing
// parity bit.
//
// A word is accepted through a valid/ready handshake. It is shifted out
// LSB-first, one bit per clock, and is followed by one parity bit. The
// parity bit makes the whole frame hold an even number of ones, or an odd
// number of ones when ODD_PARITY=1.
//
// Handshake: a word transfers on a rising clk edge where data_valid and
// data_ready are both high. data_in is sampled only on that edge. The
// source must hold data_valid and data_in until the transfer happens.
// data_ready depends only on registered state, never on data_valid.
//
// Ports:
//   clk          - system clock, rising edge active
//   reset        - asynchronous active-low reset
//   data_in      - word to transmit (DATA_BITS wide)
//   data_valid   - data_in is offered
//   data_ready   - block accepts a word this cycle (IDLE or PARITY)
//   tx_bit       - serial output bit
//   tx_active    - tx_bit carries a frame bit this cycle
//   tx_is_parity - tx_bit is the parity bit this cycle
//   frame_done   - one-cycle pulse while the parity bit is driven
//   state_dbg    - current FSM state, for observation only
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx_bit,
  output logic                 tx_active,
  output logic                 tx_is_parity,
  output logic                 frame_done,
  output tx_state_t            state_dbg
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_acc_q, par_acc_d;
  logic                 xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_acc_q <= par_acc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    par_acc_d    = par_acc_q;
    data_ready   = (state_q != SHIFT);
    tx_bit       = 1'b0;
    tx_active    = 1'b0;
    tx_is_parity = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      IDLE: begin
        // Outputs stay at their quiet defaults; loading is handled below.
      end
      SHIFT: begin
        tx_bit    = shreg_q[0];
        tx_active = 1'b1;
        par_acc_d = par_acc_q ^ shreg_q[0];
        shreg_d   = shreg_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        tx_bit       = par_acc_q;
        tx_active    = 1'b1;
        tx_is_parity = 1'b1;
        frame_done   = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A transfer can only happen in IDLE or PARITY, because data_ready is
    // low in SHIFT. Loading from PARITY overrides the return to IDLE, which
    // gives back-to-back frames with no gap bit. The accumulator is seeded
    // with ODD_PARITY so that the final XOR already holds the parity bit.
    xfer = data_valid & data_ready;
    if (xfer) begin
      shreg_d   = data_in;
      cnt_d     = '0;
      par_acc_d = ODD_PARITY;
      state_d   = SHIFT;
    end
  end

  assign state_dbg = state_q;

endmodule
